// File: rtl/sensor_pkg.sv
// Shared state type and default sizing for the line-sensor frame sequencer.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    READOUT,
    DONE
  } state_e;

  localparam int unsigned DIV_DEF     = 8;
  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned PERIOD_DEF  = 40000;
  localparam int unsigned HIGH_DEF    = 6000;
  localparam int unsigned INT_W_DEF   = 21;
  localparam int unsigned PIX_DEF     = 1024;
  localparam int unsigned PIX_W_DEF   = 11;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/eoc_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe plus a registered rising-edge pulse.
// A 0->1 input change sampled at edge k gives sig_rise high from edge k+2 to k+3.
module eoc_sync_edge (
  input  logic FPGA_CLK,
  input  logic FPGA_RST,
  input  logic sig_in,
  output logic sig_rise
);

  logic sync1_q, sync2_q, hist_q, rise_q;

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      rise_q  <= sync2_q & ~hist_q;
    end
  end

  assign sig_rise = rise_q;

endmodule

// File: rtl/sensor_frame_seq.sv
// Frame sequencer: free-running sensor clock divider, ST integration pulse and EOC pixel counter.
// Define SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN to add the READOUT timeout and sticky ERR flag.
module sensor_frame_seq
  import sensor_pkg::*;
#(
  parameter int unsigned DIV    = DIV_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned PERIOD = PERIOD_DEF,
  parameter int unsigned HIGH   = HIGH_DEF,
  parameter int unsigned INT_W  = INT_W_DEF,
  parameter int unsigned PIX    = PIX_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 65535
`endif
) (
  input  logic                   FPGA_CLK,
  input  logic                   FPGA_RST,
  input  logic                   START,
  input  logic                   CONT,
  input  logic                   EOC,
  output logic                   SENSOR_CLK,
  output logic                   ST,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  output logic [PIX_W-1:0]       EOC_COUNT,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT,
  output logic                   ERR
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(PERIOD - 1);
  localparam logic [INT_W-1:0] ST_ON    = INT_W'(PERIOD - HIGH);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(PIX);

  // Divider runs in every state; tick marks the SENSOR_CLK 0->1 cycle.
  logic [DIV_W-1:0] div_cnt_q;
  logic             sensor_clk_q;
  logic             div_wrap, tick;

  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign tick     = div_wrap & ~sensor_clk_q;

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      div_cnt_q    <= '0;
      sensor_clk_q <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_q    <= '0;
      sensor_clk_q <= ~sensor_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  logic eoc_edge;

  eoc_sync_edge u_eoc_sync (
    .FPGA_CLK (FPGA_CLK),
    .FPGA_RST (FPGA_RST),
    .sig_in   (EOC),
    .sig_rise (eoc_edge)
  );

  state_e                 state_q;
  logic [INT_W-1:0]       int_cnt_q, int_cnt_inc;
  logic [PIX_W-1:0]       eoc_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   st_q, busy_q, frame_done_q;
  logic                   start_go, last_pix;

  assign int_cnt_inc = int_cnt_q + 1'b1;
  assign last_pix    = eoc_edge && (eoc_cnt_q == PIX_LAST);

`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
  // After a timeout CONT alone may not restart; a fresh START clears this.
  logic            cont_blk_q;

  assign start_go = START | (CONT & ~cont_blk_q);
  assign ERR      = err_q;
`else
  assign start_go = START | CONT;
  assign ERR      = 1'b0;
`endif

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      state_q      <= IDLE;
      int_cnt_q    <= '0;
      eoc_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      st_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
      cont_blk_q   <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
          if (START) cont_blk_q <= 1'b0;
`endif
          if (start_go) begin
            state_q   <= INTEG;
            busy_q    <= 1'b1;
            int_cnt_q <= '0;
            eoc_cnt_q <= '0;
          end
        end
        INTEG: begin
          if (tick) begin
            if (int_cnt_q == INT_LAST) begin
              state_q   <= READOUT;
              int_cnt_q <= '0;
              st_q      <= 1'b0;
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
              to_cnt_q  <= '0;
`endif
            end else begin
              int_cnt_q <= int_cnt_inc;
              st_q      <= (int_cnt_inc >= ST_ON);
            end
          end
        end
        READOUT: begin
          if (last_pix) begin
            state_q      <= DONE;
            eoc_cnt_q    <= PIX_MAX;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 1'b1;
          end else begin
            if (eoc_edge) eoc_cnt_q <= eoc_cnt_q + 1'b1;
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
            if (tick) begin
              if (to_cnt_q == TO_LAST) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                cont_blk_q <= 1'b1;
              end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
              end
            end
`endif
          end
        end
        DONE: begin
          if (CONT) begin
            state_q   <= INTEG;
            int_cnt_q <= '0;
            eoc_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SENSOR_CLK = sensor_clk_q;
  assign ST         = st_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;
  assign EOC_COUNT  = eoc_cnt_q;
  assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_sensor_frame_seq.sv
// Directed bench for sensor_frame_seq with DIV=2, PERIOD=20, HIGH=5, PIX=4.
module tb_sensor_frame_seq;

  logic        FPGA_CLK = 1'b0;
  logic        FPGA_RST = 1'b0;
  logic        START    = 1'b0;
  logic        CONT     = 1'b0;
  logic        EOC      = 1'b0;
  logic        SENSOR_CLK, ST, BUSY, FRAME_DONE, ERR;
  logic [2:0]  EOC_COUNT;
  logic [15:0] FRAME_CNT;

  int   n_vec     = 0;
  int   n_err     = 0;
  int   done_cnt  = 0;
  int   st_rises  = 0;
  int   busy_gaps = 0;
  logic st_prev   = 1'b0;
  logic cont_win  = 1'b0;

  sensor_frame_seq #(
    .DIV    (2),
    .PERIOD (20),
    .HIGH   (5),
    .PIX    (4),
    .PIX_W  (3)
`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST   (FPGA_RST),
    .START      (START),
    .CONT       (CONT),
    .EOC        (EOC),
    .SENSOR_CLK (SENSOR_CLK),
    .ST         (ST),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .EOC_COUNT  (EOC_COUNT),
    .FRAME_CNT  (FRAME_CNT),
    .ERR        (ERR)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  always @(negedge FPGA_CLK) begin
    st_prev <= ST;
    if (FRAME_DONE) done_cnt <= done_cnt + 1;
    if (ST && !st_prev) st_rises <= st_rises + 1;
    if (cont_win && !BUSY) busy_gaps <= busy_gaps + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge FPGA_CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge FPGA_CLK);
    START = 1'b0;
  endtask

  // Three cycles high, three low; the count settles well before the task returns.
  task automatic eoc_pulse();
    @(negedge FPGA_CLK);
    EOC = 1'b1;
    cycles(3);
    EOC = 1'b0;
    cycles(3);
  endtask

  task automatic wait_st_fall(input string tag);
    int n;
    n = 0;
    while (!ST && n < 400) begin
      @(negedge FPGA_CLK);
      n++;
    end
    while (ST && n < 400) begin
      @(negedge FPGA_CLK);
      n++;
    end
    check(tag, int'(n < 400), 1);
  endtask

  initial begin
    int         rises, hi, n, base_done, base_st;
    logic       sclk_prev;
    logic [7:0] pat;
    pat = 8'b0110_0110;

    // Reset state
    cycles(3);
    check("rst_st", int'(ST), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_eoc_count", int'(EOC_COUNT), 0);
    check("rst_frame_cnt", int'(FRAME_CNT), 0);
    check("rst_frame_done", int'(FRAME_DONE), 0);
    check("rst_sensor_clk", int'(SENSOR_CLK), 0);
    check("rst_err", int'(ERR), 0);

    // SENSOR_CLK: toggles every 2 FPGA_CLK after release
    FPGA_RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge FPGA_CLK);
      check("sclk_pattern", int'(SENSOR_CLK), int'(pat[7-i]));
    end
    check("idle_busy", int'(BUSY), 0);

    // Single shot
    pulse_start();
    check("ss_busy", int'(BUSY), 1);
    n = 0;
    rises = 0;
    sclk_prev = SENSOR_CLK;
    while (!ST && n < 200) begin
      @(negedge FPGA_CLK);
      n++;
      if (SENSOR_CLK && !sclk_prev) rises++;
      sclk_prev = SENSOR_CLK;
    end
    check("ss_st_seen", int'(ST), 1);
    check("ss_st_rise_tick", rises, 15);
    hi = 0;
    while (ST && n < 400) begin
      @(negedge FPGA_CLK);
      n++;
      hi++;
    end
    check("ss_st_high_clks", hi, 20);
    check("ss_readout_count", int'(EOC_COUNT), 0);
    base_done = done_cnt;
    for (int p = 1; p <= 4; p++) begin
      eoc_pulse();
      check("ss_eoc_count", int'(EOC_COUNT), p);
    end
    cycles(2);
    check("ss_frame_done", done_cnt - base_done, 1);
    check("ss_frame_cnt", int'(FRAME_CNT), 1);
    check("ss_idle", int'(BUSY), 0);

    // EOC in INTEG ignored, START while busy ignored, saturation at PIX
    base_done = done_cnt;
    pulse_start();
    eoc_pulse();
    eoc_pulse();
    check("integ_eoc_ignored", int'(EOC_COUNT), 0);
    check("integ_busy", int'(BUSY), 1);
    pulse_start();
    wait_st_fall("sat_wait_readout");
    for (int p = 1; p <= 6; p++) begin
      eoc_pulse();
      check("sat_eoc_count", int'(EOC_COUNT), (p < 4) ? p : 4);
    end
    cycles(150);
    check("sat_hold", int'(EOC_COUNT), 4);
    check("sat_frame_done", done_cnt - base_done, 1);
    check("no_queue_busy", int'(BUSY), 0);
    check("sat_frame_cnt", int'(FRAME_CNT), 2);

    // Continuous mode, CONT dropped during frame 3
    base_done = done_cnt;
    base_st = st_rises;
    CONT = 1'b1;
    cycles(2);
    cont_win = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_st_fall("cont_wait_readout");
      if (f == 2) begin
        CONT = 1'b0;
        cont_win = 1'b0;
        pulse_start();
      end
      for (int p = 0; p < 4; p++) eoc_pulse();
    end
    cycles(150);
    check("cont_frame_done", done_cnt - base_done, 3);
    check("cont_st_pulses", st_rises - base_st, 3);
    check("cont_no_idle_gap", busy_gaps, 0);
    check("cont_frame_cnt", int'(FRAME_CNT), 5);
    check("cont_idle_after", int'(BUSY), 0);
    check("cont_eoc_count", int'(EOC_COUNT), 4);

    // Reset in the middle of READOUT
    base_done = done_cnt;
    pulse_start();
    wait_st_fall("mid_wait_readout");
    eoc_pulse();
    eoc_pulse();
    check("mid_pre_count", int'(EOC_COUNT), 2);
    #2 FPGA_RST = 1'b0;
    #1;
    check("mid_busy", int'(BUSY), 0);
    check("mid_eoc_count", int'(EOC_COUNT), 0);
    check("mid_frame_cnt", int'(FRAME_CNT), 0);
    check("mid_st", int'(ST), 0);
    check("mid_sensor_clk", int'(SENSOR_CLK), 0);
    cycles(10);
    check("mid_no_frame_done", done_cnt - base_done, 0);
    FPGA_RST = 1'b1;
    cycles(4);

`ifdef SENSOR_FRAME_SEQ_EOC_TIMEOUT_EN
    // READOUT without EOC times out after 8 ticks
    base_done = done_cnt;
    pulse_start();
    wait_st_fall("to_wait_readout");
    cycles(29);
    check("to_err_early", int'(ERR), 0);
    check("to_busy_early", int'(BUSY), 1);
    cycles(4);
    check("to_err", int'(ERR), 1);
    check("to_idle", int'(BUSY), 0);
    CONT = 1'b1;
    cycles(20);
    check("to_cont_blocked", int'(BUSY), 0);
    CONT = 1'b0;
    check("to_err_sticky", int'(ERR), 1);
    check("to_no_frame_done", done_cnt - base_done, 0);
    check("to_frame_cnt", int'(FRAME_CNT), 0);
`else
    check("err_tied_low", int'(ERR), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
